// File: rtl/vic_pkg.sv
// Shared constants, shadow-register layout and address helpers for the VIC-20 register file.
package vic_pkg;

    localparam logic [3:0] VIC_HORIG   = 4'd0;
    localparam logic [3:0] VIC_VORIG   = 4'd1;
    localparam logic [3:0] VIC_COLS    = 4'd2;
    localparam logic [3:0] VIC_ROWS    = 4'd3;
    localparam logic [3:0] VIC_RASTER  = 4'd4;
    localparam logic [3:0] VIC_MEMPTR  = 4'd5;
    localparam logic [3:0] VIC_LPX     = 4'd6;
    localparam logic [3:0] VIC_LPY     = 4'd7;
    localparam logic [3:0] VIC_POTX    = 4'd8;
    localparam logic [3:0] VIC_POTY    = 4'd9;
    localparam logic [3:0] VIC_BASS    = 4'd10;
    localparam logic [3:0] VIC_ALTO    = 4'd11;
    localparam logic [3:0] VIC_SOPRANO = 4'd12;
    localparam logic [3:0] VIC_NOISE   = 4'd13;
    localparam logic [3:0] VIC_VOLUME  = 4'd14;
    localparam logic [3:0] VIC_COLOR   = 4'd15;

    localparam logic [7:0] VIC_RST_R0  = 8'h0C;
    localparam logic [7:0] VIC_RST_R1  = 8'h26;
    localparam logic [7:0] VIC_RST_R2  = 8'h96;
    localparam logic [7:0] VIC_RST_R3  = 8'h2E;
    localparam logic [7:0] VIC_RST_R4  = 8'h00;
    localparam logic [7:0] VIC_RST_R5  = 8'hF0;
    localparam logic [7:0] VIC_RST_R6  = 8'h00;
    localparam logic [7:0] VIC_RST_R7  = 8'h00;
    localparam logic [7:0] VIC_RST_R8  = 8'hFF;
    localparam logic [7:0] VIC_RST_R9  = 8'hFF;
    localparam logic [7:0] VIC_RST_R10 = 8'h00;
    localparam logic [7:0] VIC_RST_R11 = 8'h00;
    localparam logic [7:0] VIC_RST_R12 = 8'h00;
    localparam logic [7:0] VIC_RST_R13 = 8'h00;
    localparam logic [7:0] VIC_RST_R14 = 8'h00;
    localparam logic [7:0] VIC_RST_R15 = 8'h1B;

    localparam logic [15:0] VIC_COLOR_BASE = 16'h9400;

    typedef struct packed {
        logic [6:0]  xorigin;
        logic [7:0]  yorigin;
        logic [6:0]  cols;
        logic [6:0]  rows;
        logic        chars8x16;
        logic        interlace;
        logic        inverted;
        logic [15:0] screen_addr;
        logic [15:0] char_rom_addr;
        logic [15:0] color_ram_addr;
        logic [2:0]  border_color;
        logic [3:0]  back_color;
    } vic_shadow_t;

    // VIC A13 is the inverse of CPU A15; A14/A13 of the CPU side are always zero.
    function automatic logic [15:0] vic_xlate(input logic [13:0] va);
        return {~va[13], 2'b00, va[12:0]};
    endfunction

    function automatic vic_shadow_t vic_decode(input logic [7:0] r0, input logic [7:0] r1,
                                               input logic [7:0] r2, input logic [7:0] r3,
                                               input logic [7:0] r5, input logic [7:0] r15);
        vic_shadow_t s;
        s.xorigin        = r0[6:0];
        s.interlace      = r0[7];
        s.yorigin        = r1;
        s.cols           = r2[6:0];
        s.rows           = {1'b0, r3[6:1]};
        s.chars8x16      = r3[0];
        s.screen_addr    = vic_xlate({r5[7:4], r2[7], 9'b0});
        s.char_rom_addr  = vic_xlate({r5[3:0], 10'b0});
        s.color_ram_addr = VIC_COLOR_BASE | {6'b0, r2[7], 9'b0};
        s.back_color     = r15[7:4];
        s.inverted       = r15[3];
        s.border_color   = r15[2:0];
        return s;
    endfunction

endpackage

// File: rtl/vic_addr_xlate.sv
// Combinational VIC 14-bit to CPU 16-bit address translation.
module vic_addr_xlate
    import vic_pkg::*;
(
    input  logic [13:0] va,
    output logic [15:0] cpu_addr
);

    assign cpu_addr = vic_xlate(va);

endmodule

// File: rtl/vic_regs.sv
// VIC-20 6560/6561 register file with per-frame shadowed video fields and light-pen capture.
module vic_regs
    import vic_pkg::*;
#(
    parameter logic [7:0] RST_R0  = VIC_RST_R0,
    parameter logic [7:0] RST_R1  = VIC_RST_R1,
    parameter logic [7:0] RST_R2  = VIC_RST_R2,
    parameter logic [7:0] RST_R3  = VIC_RST_R3,
    parameter logic [7:0] RST_R4  = VIC_RST_R4,
    parameter logic [7:0] RST_R5  = VIC_RST_R5,
    parameter logic [7:0] RST_R6  = VIC_RST_R6,
    parameter logic [7:0] RST_R7  = VIC_RST_R7,
    parameter logic [7:0] RST_R8  = VIC_RST_R8,
    parameter logic [7:0] RST_R9  = VIC_RST_R9,
    parameter logic [7:0] RST_R10 = VIC_RST_R10,
    parameter logic [7:0] RST_R11 = VIC_RST_R11,
    parameter logic [7:0] RST_R12 = VIC_RST_R12,
    parameter logic [7:0] RST_R13 = VIC_RST_R13,
    parameter logic [7:0] RST_R14 = VIC_RST_R14,
    parameter logic [7:0] RST_R15 = VIC_RST_R15,
    parameter int unsigned RASTER_SHIFT = 1,
    parameter int unsigned LP_HSHIFT    = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cpu_ce,
    input  logic        cpu_cs,
    input  logic        cpu_we,
    input  logic [3:0]  cpu_addr,
    input  logic [7:0]  cpu_din,
    output logic [7:0]  cpu_dout,
    input  logic [9:0]  hc,
    input  logic [9:0]  vc,
    input  logic        vs_n,
    input  logic        lp_n,
    output logic        frame_start,
    output logic [6:0]  xorigin,
    output logic [7:0]  yorigin,
    output logic [6:0]  cols,
    output logic [6:0]  rows,
    output logic        chars8x16,
    output logic        interlace,
    output logic        inverted,
    output logic [15:0] screen_addr,
    output logic [15:0] char_rom_addr,
    output logic [15:0] color_ram_addr,
    output logic [2:0]  border_color,
    output logic [3:0]  back_color,
    output logic [3:0]  aux_color,
    output logic [3:0]  volume
);

    localparam logic [7:0] RST_VAL [16] = '{RST_R0, RST_R1, RST_R2, RST_R3, RST_R4, RST_R5,
                                            RST_R6, RST_R7, RST_R8, RST_R9, RST_R10, RST_R11,
                                            RST_R12, RST_R13, RST_R14, RST_R15};
    localparam vic_shadow_t RST_SHADOW = vic_decode(RST_R0, RST_R1, RST_R2, RST_R3, RST_R5, RST_R15);

    logic [7:0]  regs     [16];
    logic [7:0]  regs_nxt [16];
    logic [7:0]  rd_data;
    logic [9:0]  vc_sh;
    logic [9:0]  hc_sh;
    logic [8:0]  raster;
    logic        vs_prev;
    logic        lp_prev;
    logic        lp_armed;
    logic        vs_fall;
    logic        lp_fall;
    logic        wr_en;
    logic        rd_en;
    logic [15:0] scr_cpu;
    logic [15:0] chr_cpu;
    vic_shadow_t live;
    vic_shadow_t shadow;
    logic        unused_bits;

    assign vc_sh   = vc >> RASTER_SHIFT;
    assign hc_sh   = hc >> LP_HSHIFT;
    assign raster  = vc_sh[8:0];
    assign vs_fall = vs_prev & ~vs_n;
    assign lp_fall = lp_prev & ~lp_n;
    assign wr_en   = cpu_ce & cpu_cs & cpu_we;
    assign rd_en   = cpu_ce & cpu_cs & ~cpu_we;
    assign unused_bits = ^{vc_sh[9], hc_sh[9:8]};

    // Next register image includes this cycle's write so a write on the commit edge lands in that frame.
    always_comb begin
        for (int unsigned i = 0; i < 16; i++) regs_nxt[i] = regs[i];
        if (wr_en) begin
            case (cpu_addr)
                VIC_ROWS: regs_nxt[VIC_ROWS] = {regs[VIC_ROWS][7], cpu_din[6:0]};
                VIC_RASTER, VIC_LPX, VIC_LPY, VIC_POTX, VIC_POTY: ;
                default: regs_nxt[cpu_addr] = cpu_din;
            endcase
        end
        if (lp_fall && (lp_armed || vs_fall)) begin
            regs_nxt[VIC_LPX] = hc_sh[7:0];
            regs_nxt[VIC_LPY] = raster[8:1];
        end
    end

    always_comb begin
        rd_data = regs[cpu_addr];
        case (cpu_addr)
            VIC_ROWS:           rd_data = {raster[0], regs[VIC_ROWS][6:0]};
            VIC_RASTER:         rd_data = raster[8:1];
            VIC_POTX, VIC_POTY: rd_data = '1;
            default: ;
        endcase
    end

    vic_addr_xlate u_scr_xlate (
        .va       ({regs_nxt[VIC_MEMPTR][7:4], regs_nxt[VIC_COLS][7], 9'b0}),
        .cpu_addr (scr_cpu)
    );

    vic_addr_xlate u_chr_xlate (
        .va       ({regs_nxt[VIC_MEMPTR][3:0], 10'b0}),
        .cpu_addr (chr_cpu)
    );

    always_comb begin
        live                = '0;
        live.xorigin        = regs_nxt[VIC_HORIG][6:0];
        live.interlace      = regs_nxt[VIC_HORIG][7];
        live.yorigin        = regs_nxt[VIC_VORIG];
        live.cols           = regs_nxt[VIC_COLS][6:0];
        live.rows           = {1'b0, regs_nxt[VIC_ROWS][6:1]};
        live.chars8x16      = regs_nxt[VIC_ROWS][0];
        live.screen_addr    = scr_cpu;
        live.char_rom_addr  = chr_cpu;
        live.color_ram_addr = VIC_COLOR_BASE | {6'b0, regs_nxt[VIC_COLS][7], 9'b0};
        live.back_color     = regs_nxt[VIC_COLOR][7:4];
        live.inverted       = regs_nxt[VIC_COLOR][3];
        live.border_color   = regs_nxt[VIC_COLOR][2:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < 16; i++) regs[i] <= RST_VAL[i];
            cpu_dout    <= '0;
            frame_start <= 1'b0;
            vs_prev     <= 1'b1;
            lp_prev     <= 1'b1;
            lp_armed    <= 1'b1;
            shadow      <= RST_SHADOW;
        end else begin
            for (int unsigned i = 0; i < 16; i++) regs[i] <= regs_nxt[i];
            if (rd_en) cpu_dout <= rd_data;
            frame_start <= vs_fall;
            vs_prev     <= vs_n;
            lp_prev     <= lp_n;
            if (vs_fall) begin
                shadow   <= live;
                lp_armed <= 1'b1;
            end else if (lp_fall) begin
                lp_armed <= 1'b0;
            end
        end
    end

    assign xorigin        = shadow.xorigin;
    assign yorigin        = shadow.yorigin;
    assign cols           = shadow.cols;
    assign rows           = shadow.rows;
    assign chars8x16      = shadow.chars8x16;
    assign interlace      = shadow.interlace;
    assign inverted       = shadow.inverted;
    assign screen_addr    = shadow.screen_addr;
    assign char_rom_addr  = shadow.char_rom_addr;
    assign color_ram_addr = shadow.color_ram_addr;
    assign border_color   = shadow.border_color;
    assign back_color     = shadow.back_color;
    assign aux_color      = regs[VIC_VOLUME][7:4];
    assign volume         = regs[VIC_VOLUME][3:0];

endmodule

// File: doc/vic_regs.md
Name: vic_regs

Overview:
- VIC-20 6560/6561 register file feeding the VGA character renderer that sits directly downstream.
- Decodes CPU accesses to $9000-$900F and holds the 16 registers.
- Translates VIC 14-bit addresses into the CPU-space bases the renderer consumes.
- Exposes raster and light-pen readback; video-facing fields are double-buffered and committed once per frame.

Parameters:
- RST_R0..RST_R15, defaults 8'h0C, 8'h26, 8'h96, 8'h2E, 8'h00, 8'hF0, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h1B: power-on value of each register.
- RASTER_SHIFT, default 1: right shift applied to vc to form the 9-bit raster line.
- LP_HSHIFT, default 2: right shift applied to hc to form the light-pen X value.

Ports:
- clk  in  1  system/pixel clock
- reset_n  in  1  asynchronous, active-low reset
- cpu_ce  in  1  one-cycle CPU bus strobe
- cpu_cs  in  1  register-window select
- cpu_we  in  1  1 = write
- cpu_addr  in  4  register index
- cpu_din  in  8  write data
- cpu_dout  out  8  registered read data
- hc  in  10  renderer horizontal count
- vc  in  10  renderer vertical count
- vs_n  in  1  renderer vga_vs, active low
- lp_n  in  1  light-pen input, active low, already synchronised
- frame_start  out  1  one-cycle pulse on commit
- xorigin  out  7
- yorigin  out  8
- cols  out  7
- rows  out  7
- chars8x16  out  1
- interlace  out  1
- inverted  out  1
- screen_addr  out  16
- char_rom_addr  out  16
- color_ram_addr  out  16
- border_color  out  3
- back_color  out  4
- aux_color  out  4
- volume  out  4

Behaviour:
- Reset (async on reset_n low):
  - R[i] = RST_Ri.
  - cpu_dout = 0; frame_start = 0; light pen armed.
  - Shadow outputs load directly from RST values, so the power-on screen is at $1E00, chars at $8000, colour RAM at $9600, 22x23, border 3, background 1, inverted 1.
- Write: on clk when cpu_ce & cpu_cs & cpu_we, R[cpu_addr] <= cpu_din.
  - Writes to index 3 update only bits 6:0; bit 7 is read-only.
  - Writes to indices 4, 6, 7, 8 and 9 are ignored.
- Read: when cpu_ce & cpu_cs & ~cpu_we, cpu_dout <= mux on the next edge (latency 1); it holds otherwise.
  - Index 3 returns {raster[0], R3[6:0]}.
  - Index 4 returns raster[8:1].
  - Indices 6 and 7 return the light-pen latches; 8 and 9 return 8'hFF.
  - raster = vc >> RASTER_SHIFT, 9 bits, sampled combinationally.
- Field decode (live):
  - R0: interlace = [7], xorigin = [6:0].
  - R1: yorigin.
  - R2: va9 = [7], cols = [6:0].
  - R3: rows = [6:1], zero-extended to 7 bits; chars8x16 = [0].
  - R5: scr = [7:4], chr = [3:0].
  - R14: aux_color = [7:4], volume = [3:0].
  - R15: back_color = [7:4], inverted = [3], border_color = [2:0].
- Address translation: VIC 14-bit address VA maps to CPU {~VA[13], 2'b00, VA[12:0]}.
  - screen VA = {scr, va9, 9'b0}.
  - char VA = {chr, 10'b0}.
  - color_ram_addr = 16'h9400 | {6'b0, va9, 9'b0}.
- Commit:
  - vs_n falling edge is detected with a registered copy.
  - On that edge, all shadow outputs load the live decode and frame_start pulses for 1 cycle.
  - A write on the same cycle as the edge is included in that commit.
  - volume and aux_color bypass the shadow and are live.
- Light pen:
  - While armed, the first lp_n falling edge latches R6 = hc >> LP_HSHIFT (low 8 bits) and R7 = raster[8:1], then disarms.
  - Commit re-arms.
  - An lp_n edge coincident with a commit is latched, and the block is left armed.
- reset_n low mid-frame: shadows return to RST decode immediately; no frame_start pulse is issued for that frame.

Decomposition:
- Package vic_pkg holds:
  - register index localparams (VIC_HORIG = 0 .. VIC_COLOR = 15);
  - the default reset byte constants;
  - the fixed 16'h9400 colour base.
- Sub-module vic_addr_xlate is purely combinational, instantiated twice (screen and char): input 14-bit VA, output 16-bit CPU address.

Test Plan:
- Reset release, then a forced vs_n falling edge -> screen_addr 16'h1E00, char_rom_addr 16'h8000, color_ram_addr 16'h9600, cols 22, rows 23, border 3, back 1.
- Write R5 = 8'hCC and R2 = 8'h16 mid-frame -> outputs unchanged until the vs_n fall; after the edge:
  - screen_addr 16'h1000;
  - char_rom_addr 16'h1000 (VA 13'h3000 -> 16'h1000);
  - color_ram_addr 16'h9400;
  - frame_start high exactly 1 cycle.
- vc = 10'd301 with read of index 4 then index 3 -> cpu_dout 8'h4B, then bit7 = 0 (raster 150); vc = 303 -> index 3 bit7 = 1.
- Write R3 = 8'hFF -> read returns {raster0, 7'h7F}; next commit gives rows 63, chars8x16 1.
- lp_n pulses at hc = 400 / vc = 200, then again at hc = 100 -> R6 = 8'd100, R7 = 8'd50; the second pulse is ignored until the next commit.
- reset_n asserted mid-frame after R15 = 8'h00 committed -> border_color 3 and back_color 1 immediately, cpu_dout 0.
